// File: rtl/opb_register_pkg.sv
// Shared definitions for the OPB register bank: transfer FSM encoding and
// byte-enable expansion.
package opb_register_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  // be[3] is the first OPB lane and covers the most significant byte.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{be[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/opb_register_cell.sv
// One 32-bit byte-enabled user register with an optional self-clearing mode
// and a write strobe aligned with the cycle the new value becomes visible.
module opb_register_cell #(
  parameter bit PULSE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] mask,
  input  logic [31:0] wdata,
  output logic [31:0] q,
  output logic        strobe
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= we;
      if (we) begin
        q <= (q & ~mask) | (wdata & mask);
      end else if (PULSE) begin
        q <= '0;
      end
    end
  end

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave exposing C_NUM_REGS 32-bit user registers in a decoded window;
// every transfer walks IDLE -> DECODE -> ACK and acks two cycles after the hit.
module opb_register_bank
  import opb_register_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01003100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010031FF,
  parameter int          C_NUM_REGS   = 8,
  parameter logic [63:0] C_PULSE_MASK = 64'h0
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:31]                OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:31]                OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:31]                Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_wr_strobe
);

  state_t                state, state_nxt;
  logic [31:0]           addr, offset;
  logic [31:0]           idx_p1, wdata_p1, mask_p1;
  logic                  rnw_p1;
  logic                  hit, err;
  logic [C_NUM_REGS-1:0] we;
  logic [31:0]           rd_data;
  logic                  unused_seq;

  assign addr       = OPB_ABus;
  assign offset     = addr - C_BASEADDR;
  assign hit        = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign unused_seq = OPB_seqAddr;
  assign err        = (idx_p1 >= 32'(C_NUM_REGS));

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // DECODE -> ACK: request fields are frozen here for the whole ACK cycle.
  always_ff @(posedge OPB_Clk) begin
    if (state == ST_DECODE) begin
      idx_p1   <= offset >> 2;
      wdata_p1 <= OPB_DBus;
      mask_p1  <= be_to_mask(OPB_BE);
      rnw_p1   <= OPB_RNW;
    end
  end

  always_comb begin
    state_nxt  = state;
    Sl_xferAck = 1'b0;
    Sl_errAck  = 1'b0;
    we         = '0;
    case (state)
      ST_IDLE:   if (hit) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = OPB_select ? ST_ACK : ST_IDLE;
      ST_ACK: begin
        state_nxt  = ST_IDLE;
        Sl_xferAck = !err;
        Sl_errAck  = err;
        for (int i = 0; i < C_NUM_REGS; i++) begin
          we[i] = !err && !rnw_p1 && (idx_p1 == 32'(i));
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx_p1 == 32'(i)) rd_data = user_data_out[i*32 +: 32];
    end
  end

  assign Sl_DBus    = (state == ST_ACK && rnw_p1 && !err) ? rd_data : '0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg
    opb_register_cell #(
      .PULSE (C_PULSE_MASK[g])
    ) u_cell (
      .clk    (OPB_Clk),
      .rst_n  (OPB_Rst),
      .we     (we[g]),
      .mask   (mask_p1),
      .wdata  (wdata_p1),
      .q      (user_data_out[g*32 +: 32]),
      .strobe (user_wr_strobe[g])
    );
  end

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed bench for opb_register_bank: a transaction-level model of the
// register contents and bus response, compared against the DUT every cycle.
module tb_opb_register_bank;

  localparam logic [31:0] BASE  = 32'h01003100;
  localparam logic [31:0] HIGH  = 32'h010031FF;
  localparam int          NREGS = 8;
  localparam logic [63:0] PMASK = 64'h1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [0:31]       abus = '0;
  logic [0:3]        be_s = '0;
  logic [0:31]       dbus = '0;
  logic              rnw_s = 1'b0;
  logic              sel = 1'b0;
  logic              seq = 1'b0;
  logic [0:31]       sl_dbus;
  logic              sl_xfer, sl_err, sl_retry, sl_tout;
  logic [NREGS*32-1:0] udata;
  logic [NREGS-1:0]  ustrobe;

  logic [31:0] model [NREGS];
  logic        exp_ack, exp_err;
  logic [31:0] exp_dbus;
  logic [7:0]  exp_strobe;
  logic        chk_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

  opb_register_bank #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_NUM_REGS   (NREGS),
    .C_PULSE_MASK (PMASK)
  ) dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst),
    .OPB_ABus       (abus),
    .OPB_BE         (be_s),
    .OPB_DBus       (dbus),
    .OPB_RNW        (rnw_s),
    .OPB_select     (sel),
    .OPB_seqAddr    (seq),
    .Sl_DBus        (sl_dbus),
    .Sl_xferAck     (sl_xfer),
    .Sl_errAck      (sl_err),
    .Sl_retry       (sl_retry),
    .Sl_toutSup     (sl_tout),
    .user_data_out  (udata),
    .user_wr_strobe (ustrobe)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("xferAck", 32'(sl_xfer), 32'(exp_ack));
      chk("errAck", 32'(sl_err), 32'(exp_err));
      chk("Sl_DBus", sl_dbus, exp_dbus);
      chk("strobe", 32'(ustrobe), 32'(exp_strobe));
      chk("retry_tout", {30'b0, sl_retry, sl_tout}, 32'h0);
      for (int i = 0; i < NREGS; i++) begin
        chk($sformatf("reg%0d", i), udata[i*32 +: 32], model[i]);
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    exp_ack = 1'b0; exp_err = 1'b0; exp_dbus = '0; exp_strobe = '0;
  endfunction

  // Advance one clock; pulse registers fall back to zero, strobes last one cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    exp_strobe = '0;
    for (int i = 0; i < NREGS; i++) if (PMASK[i]) model[i] = '0;
  endtask

  // One OPB transfer: c0 hit, c1 decode, c2 ack, c3 first idle cycle after.
  // Returns at the falling edge of c3.
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [0:3] be,
                      input logic [31:0] data, input logic abort,
                      output int ack_cyc, output int err_cyc, output logic [31:0] rdata);
    logic [31:0] idx, mask, merged;
    logic        hit, err;
    hit  = (addr >= BASE) && (addr <= HIGH);
    idx  = (addr - BASE) >> 2;
    err  = (idx >= 32'(NREGS));
    mask = '0;
    for (int k = 0; k < 4; k++) if (be[k]) mask[31-8*k -: 8] = 8'hFF;
    merged = '0;
    ack_cyc = -1; err_cyc = -1; rdata = '0;
    cycle();
    sel = 1'b1; abus = addr; dbus = data; be_s = be; rnw_s = rnw;
    for (int c = 0; c < 4; c++) begin
      if (c == 1 && abort) sel = 1'b0;
      if (c == 2 && hit && !abort) begin
        exp_ack  = !err;
        exp_err  = err;
        exp_dbus = (rnw && !err) ? model[idx[2:0]] : '0;
        merged   = (model[idx[2:0]] & ~mask) | (data & mask);
      end
      if (c == 3) begin
        sel = 1'b0;
        if (hit && !abort) begin
          exp_ack = 1'b0; exp_err = 1'b0; exp_dbus = '0;
          if (!rnw && !err) begin
            model[idx[2:0]] = merged;
            exp_strobe[idx[2:0]] = 1'b1;
          end
        end
      end
      @(negedge clk);
      if (sl_xfer && ack_cyc < 0) ack_cyc = c;
      if (sl_err && err_cyc < 0) err_cyc = c;
      if (c == 2) rdata = sl_dbus;
      if (c < 3) cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t required below 200000", $time);
    $fatal(1);
  end

  initial begin
    int          ac, ec;
    logic [31:0] rd;
    model_reset();
    #3 rst = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_reg1", udata[63:32], 32'h0);
    @(posedge clk); #2 rst = 1'b1;

    // Full-word write then byte-lane merge and readback of register 1.
    xfer(1'b0, BASE + 32'h4, 4'b1111, 32'hDEADBEEF, 1'b0, ac, ec, rd);
    chk("wr_latency", 32'(ac), 32'd2);
    chk("wr_reg1", udata[63:32], 32'hDEADBEEF);
    chk("wr_strobe", 32'(ustrobe), 32'h2);
    xfer(1'b0, BASE + 32'h4, 4'b0100, 32'h11223344, 1'b0, ac, ec, rd);
    chk("be_reg1", udata[63:32], 32'hDE22BEEF);
    xfer(1'b1, BASE + 32'h4, 4'b1111, 32'h0, 1'b0, ac, ec, rd);
    chk("rd_data", rd, 32'hDE22BEEF);
    chk("rd_latency", 32'(ac), 32'd2);

    // Out-of-range index inside the window.
    xfer(1'b0, BASE + 32'h20, 4'b1111, 32'hFFFFFFFF, 1'b0, ac, ec, rd);
    chk("oor_xfer", 32'(ac), 32'hFFFFFFFF);
    chk("oor_err", 32'(ec), 32'd2);
    xfer(1'b1, BASE + 32'h3C, 4'b1111, 32'h0, 1'b0, ac, ec, rd);
    chk("oor_rd_err", 32'(ec), 32'd2);

    // Self-clearing register 0.
    xfer(1'b0, BASE, 4'b1111, 32'h5, 1'b0, ac, ec, rd);
    chk("pulse_set", udata[31:0], 32'h5);
    cycle();
    chk("pulse_clr", udata[31:0], 32'h0);

    // Master abort in DECODE, then a normal transfer to the same register.
    xfer(1'b0, BASE + 32'hC, 4'b1111, 32'hCAFEF00D, 1'b1, ac, ec, rd);
    chk("abort_ack", 32'(ac), 32'hFFFFFFFF);
    chk("abort_reg3", udata[127:96], 32'h0);
    xfer(1'b0, BASE + 32'hC, 4'b1111, 32'h12345678, 1'b0, ac, ec, rd);
    chk("post_abort_ack", 32'(ac), 32'd2);
    chk("post_abort_reg3", udata[127:96], 32'h12345678);

    // Empty byte enables still ack and strobe; mixed lanes on register 7.
    xfer(1'b0, BASE + 32'hC, 4'b0000, 32'hFFFFFFFF, 1'b0, ac, ec, rd);
    chk("be0_strobe", 32'(ustrobe), 32'h8);
    chk("be0_reg3", udata[127:96], 32'h12345678);
    xfer(1'b0, BASE + 32'h1C, 4'b1001, 32'hA1B2C3D4, 1'b0, ac, ec, rd);
    chk("be1001_reg7", udata[255:224], 32'hA10000D4);
    xfer(1'b1, BASE + 32'h1C, 4'b1111, 32'h0, 1'b0, ac, ec, rd);
    chk("rd_reg7", rd, 32'hA10000D4);

    // Addresses outside the window are never decoded.
    xfer(1'b0, BASE + 32'h200, 4'b1111, 32'h77777777, 1'b0, ac, ec, rd);
    chk("miss_ack", 32'(ac), 32'hFFFFFFFF);
    xfer(1'b0, BASE - 32'h4, 4'b1111, 32'h77777777, 1'b0, ac, ec, rd);
    chk("miss_low_err", 32'(ec), 32'hFFFFFFFF);

    // Reset asserted in the middle of the ACK cycle of a write.
    cycle();
    sel = 1'b1; abus = BASE + 32'h8; dbus = 32'hA5A5A5A5; be_s = 4'b1111; rnw_s = 1'b0;
    cycle();
    cycle();
    exp_ack = 1'b1;
    #1 chk("pre_rst_ack", 32'(sl_xfer), 32'h1);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_ack", 32'(sl_xfer), 32'h0);
    chk("rst_dbus", sl_dbus, 32'h0);
    chk("rst_reg3", udata[127:96], 32'h0);
    sel = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    cycle();
    chk("rst_reg2", udata[95:64], 32'h0);
    chk("rst_strobe", 32'(ustrobe), 32'h0);

    xfer(1'b0, BASE + 32'h8, 4'b0011, 32'h0000BEEF, 1'b0, ac, ec, rd);
    chk("post_rst_reg2", udata[95:64], 32'h0000BEEF);
    cycle();
    cycle();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
